mcycle_timer: RTL and testbench
===============================

MCYCLE_TIMER -- requirements
Module: mcycle_timer

Interface
REQ-001 Parameter NUM_S, default 6: S-states per machine cycle; SHALL be even and at least 4; H = NUM_S/2.
REQ-002 Parameter CYC_W, default 2: width of the remaining-machine-cycle counter.
REQ-003 Parameter WAIT_EN, default 1: 1 enables ready-driven wait-state insertion; 0 ignores ready.
REQ-004 clk  in  1  single system clock; all state changes on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cycles_in  in  CYC_W  extra machine cycles needed by the opcode being fetched.
REQ-007 movx  in  1  current instruction performs an external data access.
REQ-008 movx_wr  in  1  external access is a write (1) or read (0).
REQ-009 ready  in  1  external memory ready; low requests a wait state.
REQ-010 Phase  out  1  0 = P1, 1 = P2.
REQ-011 S  out  $clog2(NUM_S+1)  current S-state index, 1..NUM_S.
REQ-012 cycles  out  CYC_W  machine cycles remaining after the current one.
REQ-013 ALE, PSEN, RD, WR  out  1 each  bus strobes; ALE active-high, others active-low.
REQ-014 ir_load  out  1  one-clock strobe meaning the opcode byte is valid and is loaded into IR.
REQ-015 waiting  out  1  high while a wait state is being inserted.

Function
REQ-016 Phase SHALL toggle on every clk.
REQ-017 S SHALL advance on each clk where Phase=1 and SHALL wrap from NUM_S to 1, except when a wait applies (REQ-018).
REQ-018 If WAIT_EN=1, S=H, Phase=1 and ready=0, S SHALL hold, Phase SHALL keep toggling, and waiting SHALL be 1 until the first Phase=1 clk with ready=1.
REQ-019 On the wrap NUM_S->1: if cycles=0, cycles SHALL load cycles_in; otherwise cycles SHALL decrement by 1. There is no wrap below 0.
REQ-020 ir_load SHALL be 1 exactly during S=NUM_S, Phase=1, cycles=0.
REQ-021 movx_cycle is defined as movx=1 AND cycles=0 AND the instruction loaded a nonzero cycles_in.
REQ-022 Window A is S1..SH; window B is S(H+1)..S(NUM_S).
REQ-023 ALE SHALL be 1 during both phases of S1 and of S(H+1), except during S1 of a movx_cycle, where it SHALL be 0.
REQ-024 PSEN SHALL be 0 from S2 P2 (S(H+2) P2 for window B) through the last state of that window, including held wait states.
REQ-025 In a movx_cycle, PSEN SHALL stay 1 for all of window A.
REQ-026 In a movx_cycle, RD (movx_wr=0) or WR (movx_wr=1) SHALL be 0 from S1 P2 through SH P2, including wait states; RD and WR SHALL be 1 at all other times.
REQ-027 RD and WR SHALL never be 0 simultaneously, and neither SHALL be 0 in the same clk as PSEN=0.
REQ-028 All outputs SHALL be registered and SHALL change only on posedge clk, with no combinational path from any input.
REQ-029 cycles_in and movx SHALL be sampled only at the wrap where cycles=0; changes at other times SHALL have no effect.

Reset
REQ-030 While reset=1: Phase=0, S=NUM_S, cycles=0, ALE=0, PSEN=1, RD=1, WR=1, ir_load=0, waiting=0.
REQ-031 Asserting reset mid-cycle or mid-wait SHALL abort the access at the next posedge.
REQ-032 After release, the first clk SHALL be S=NUM_S P2 with ir_load=1, and S1 SHALL follow.

Structure
REQ-033 The S-state encoding helper, the window boundary functions (H and its derivations) and the strobe polarity constants SHALL reside in the shared package mcu_timing_pkg.
REQ-034 One sub-module, mcycle_strobe, SHALL decode the next S, Phase, cycles and movx_cycle into registered ALE, PSEN, RD and WR.
REQ-035 Phase, S and cycles SHALL be held in the top-level module.

Verification
REQ-036 NUM_S=6; release reset, cycles_in=0, ready=1 -> S sequence 6,1..6 repeating, 12 clks per cycle, ALE high in S1 and S4, ir_load once every 12 clks.
REQ-037 cycles_in=2 at fetch -> cycles reads 2, 1, 0 across successive machine cycles, and ir_load is absent for 24 clks.
REQ-038 movx=1, movx_wr=0, cycles_in=1 -> in the second cycle, ALE=0 in S1, PSEN=1 in S1-S3, RD=0 from S1P2 through S3P2, and WR stays 1.
REQ-039 ready=0 for 4 clks at S3 P2 -> S holds at 3 for 2 extra states, waiting=1, PSEN stays 0, and S4 follows with ready=1.
REQ-040 NUM_S=8, WAIT_EN=0 -> ALE high in S1 and S5, ready ignored, 16 clks per cycle.
REQ-041 reset pulse during RD=0 -> RD=1 on the next clk, and the REQ-032 restart sequence follows.

Source files
------------

// File: rtl/mcu_timing_pkg.sv
// Shared machine-cycle timing helpers: S-state stepping, window boundaries
// and bus strobe polarities.
package mcu_timing_pkg;

    typedef int unsigned uint_t;

    localparam logic ALE_ON  = 1'b1;
    localparam logic ALE_OFF = 1'b0;
    localparam logic STB_ON  = 1'b0;
    localparam logic STB_OFF = 1'b1;

    function automatic uint_t half_of(input uint_t num_s);
        return num_s / 2;
    endfunction

    function automatic uint_t s_width(input uint_t num_s);
        return uint_t'($clog2(num_s + 1));
    endfunction

    function automatic uint_t s_next(input uint_t s, input uint_t num_s);
        return (s >= num_s) ? 32'd1 : s + 32'd1;
    endfunction

    function automatic logic in_window_a(input uint_t s, input uint_t num_s);
        return (s >= 32'd1) && (s <= half_of(num_s));
    endfunction

    // 1-based S position inside its own window (A or B).
    function automatic uint_t window_off(input uint_t s, input uint_t num_s);
        return in_window_a(s, num_s) ? s : s - half_of(num_s);
    endfunction

endpackage

// File: rtl/mcycle_timer_if.sv
// Bus-side signal bundle of the machine-cycle timer.
interface mcycle_timer_if import mcu_timing_pkg::*; #(
    parameter int unsigned NUM_S = 6,
    parameter int unsigned CYC_W = 2
);
    localparam int unsigned SW = s_width(NUM_S);

    logic [CYC_W-1:0] cycles_in;
    logic             movx;
    logic             movx_wr;
    logic             ready;
    logic             Phase;
    logic [SW-1:0]    S;
    logic [CYC_W-1:0] cycles;
    logic             ALE;
    logic             PSEN;
    logic             RD;
    logic             WR;
    logic             ir_load;
    logic             waiting;

    modport master (
        input  cycles_in, movx, movx_wr, ready,
        output Phase, S, cycles, ALE, PSEN, RD, WR, ir_load, waiting
    );

    modport slave (
        output cycles_in, movx, movx_wr, ready,
        input  Phase, S, cycles, ALE, PSEN, RD, WR, ir_load, waiting
    );
endinterface

// File: rtl/mcycle_strobe.sv
// Registered ALE/PSEN/RD/WR decode, driven from the timer's next-state values
// so the strobes line up with the registered S/Phase.
module mcycle_strobe import mcu_timing_pkg::*; #(
    parameter int unsigned NUM_S = 6,
    parameter int unsigned CYC_W = 2,
    parameter int unsigned SW    = s_width(NUM_S)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SW-1:0]    s_i,
    input  logic             phase_i,
    input  logic [CYC_W-1:0] cycles_i,
    input  logic             movx_i,
    input  logic             movx_wr_i,
    output logic             ale_o,
    output logic             psen_o,
    output logic             rd_o,
    output logic             wr_o
);
    uint_t s, off;
    logic  win_a, movx_cycle, xfer;
    logic  ale_d, psen_d, rd_d, wr_d;
    logic  ale_q, psen_q, rd_q, wr_q;

    always_comb begin
        s          = uint_t'(s_i);
        off        = window_off(s, NUM_S);
        win_a      = in_window_a(s, NUM_S);
        movx_cycle = movx_i && (cycles_i == '0);
        // Data strobe spans S1 P2 .. SH P2 of window A, wait states included.
        xfer       = movx_cycle && win_a && ((off > 32'd1) || phase_i);
        ale_d      = ((off == 32'd1) && !(movx_cycle && win_a)) ? ALE_ON : ALE_OFF;
        psen_d     = (((off == 32'd2 && phase_i) || off > 32'd2) && !(movx_cycle && win_a))
                     ? STB_ON : STB_OFF;
        rd_d       = (xfer && !movx_wr_i) ? STB_ON : STB_OFF;
        wr_d       = (xfer && movx_wr_i) ? STB_ON : STB_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ale_q  <= ALE_OFF;
            psen_q <= STB_OFF;
            rd_q   <= STB_OFF;
            wr_q   <= STB_OFF;
        end else begin
            ale_q  <= ale_d;
            psen_q <= psen_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
        end
    end

    assign ale_o  = ale_q;
    assign psen_o = psen_q;
    assign rd_o   = rd_q;
    assign wr_o   = wr_q;
endmodule

// File: rtl/mcycle_timer.sv
// Machine-cycle timer: S-state/phase sequencer with wait-state insertion,
// remaining-cycle counter and registered bus strobes.
module mcycle_timer import mcu_timing_pkg::*; #(
    parameter int unsigned NUM_S   = 6,
    parameter int unsigned CYC_W   = 2,
    parameter int unsigned WAIT_EN = 1
) (
    input logic            clk,
    input logic            reset,
    mcycle_timer_if.master bus
);
    localparam int unsigned SW = s_width(NUM_S);
    localparam int unsigned H  = half_of(NUM_S);

    logic             phase_q, phase_d;
    logic [SW-1:0]    s_q, s_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic             movx_q, movx_d;
    logic             wr_sel_q, wr_sel_d;
    logic             waiting_q, waiting_d;
    logic             ir_load_q, ir_load_d;
    logic             hold, wrap;
    logic             ale, psen, rd, wr;

    always_comb begin
        hold     = (WAIT_EN != 0) && phase_q && (s_q == SW'(H)) && !bus.ready;
        wrap     = phase_q && (s_q == SW'(NUM_S));
        phase_d  = ~phase_q;
        s_d      = s_q;
        cycles_d = cycles_q;
        movx_d   = movx_q;
        wr_sel_d = wr_sel_q;
        if (phase_q && !hold) begin
            s_d = SW'(s_next(uint_t'(s_q), NUM_S));
        end
        // Opcode attributes are only sampled at the fetch boundary.
        if (wrap) begin
            if (cycles_q == '0) begin
                cycles_d = bus.cycles_in;
                movx_d   = bus.movx && (bus.cycles_in != '0);
                wr_sel_d = bus.movx_wr;
            end else begin
                cycles_d = cycles_q - CYC_W'(1);
            end
        end
        waiting_d = phase_q ? hold : waiting_q;
        ir_load_d = phase_d && (s_d == SW'(NUM_S)) && (cycles_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= 1'b0;
            s_q       <= SW'(NUM_S);
            cycles_q  <= '0;
            movx_q    <= 1'b0;
            wr_sel_q  <= 1'b0;
            waiting_q <= 1'b0;
            ir_load_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            s_q       <= s_d;
            cycles_q  <= cycles_d;
            movx_q    <= movx_d;
            wr_sel_q  <= wr_sel_d;
            waiting_q <= waiting_d;
            ir_load_q <= ir_load_d;
        end
    end

    mcycle_strobe #(
        .NUM_S (NUM_S),
        .CYC_W (CYC_W),
        .SW    (SW)
    ) u_strobe (
        .clk       (clk),
        .reset     (reset),
        .s_i       (s_d),
        .phase_i   (phase_d),
        .cycles_i  (cycles_d),
        .movx_i    (movx_d),
        .movx_wr_i (wr_sel_d),
        .ale_o     (ale),
        .psen_o    (psen),
        .rd_o      (rd),
        .wr_o      (wr)
    );

    assign bus.Phase   = phase_q;
    assign bus.S       = s_q;
    assign bus.cycles  = cycles_q;
    assign bus.ALE     = ale;
    assign bus.PSEN    = psen;
    assign bus.RD      = rd;
    assign bus.WR      = wr;
    assign bus.ir_load = ir_load_q;
    assign bus.waiting = waiting_q;
endmodule

// File: tb/tb_mcycle_timer.sv
// Randomized bench for mcycle_timer: a 6-state waiting instance and an
// 8-state no-wait instance checked against a half-state timeline model.
module tb_mcycle_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] cycles_in;
    logic       movx, movx_wr, ready;

    int n_cmp = 0;
    int n_err = 0;

    mcycle_timer_if #(.NUM_S(6), .CYC_W(2)) bus6 ();
    mcycle_timer_if #(.NUM_S(8), .CYC_W(2)) bus8 ();

    assign bus6.cycles_in = cycles_in;
    assign bus6.movx      = movx;
    assign bus6.movx_wr   = movx_wr;
    assign bus6.ready     = ready;
    assign bus8.cycles_in = cycles_in;
    assign bus8.movx      = movx;
    assign bus8.movx_wr   = movx_wr;
    assign bus8.ready     = ready;

    mcycle_timer #(.NUM_S(6), .CYC_W(2), .WAIT_EN(1)) u_dut6 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus6)
    );

    mcycle_timer #(.NUM_S(8), .CYC_W(2), .WAIT_EN(0)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    always #5 clk = ~clk;

    // hs = half-state index in the machine cycle: 2*(S-1) + Phase.
    typedef struct {
        int hs;
        int cyc;
        bit mx;
        bit wr;
        bit wt;
        bit in_rst;
    } mdl_t;

    mdl_t m [2];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input int ns, input bit we);
        int h;
        h = ns / 2;
        if (reset) begin
            m[i].hs = 2 * ns - 2;
            m[i].cyc = 0;
            m[i].mx = 0;
            m[i].wr = 0;
            m[i].wt = 0;
            m[i].in_rst = 1;
            return;
        end
        m[i].in_rst = 0;
        if (we && m[i].hs == 2 * h - 1 && !ready) begin
            m[i].hs = 2 * h - 2;  // replay SH
            m[i].wt = 1;
        end else begin
            if (m[i].hs % 2 == 1) m[i].wt = 0;
            if (m[i].hs == 2 * ns - 1) begin
                if (m[i].cyc == 0) begin
                    m[i].cyc = int'(cycles_in);
                    m[i].mx = movx && (cycles_in != 0);
                    m[i].wr = movx_wr;
                end else begin
                    m[i].cyc = m[i].cyc - 1;
                end
                m[i].hs = 0;
            end else begin
                m[i].hs = m[i].hs + 1;
            end
        end
    endtask

    task automatic check_inst(input int i, input int ns, input int ph, input int s,
                              input int cyc, input int ale, input int psen, input int rd,
                              input int wr, input int ir, input int wt);
        int h, es, eph, win, k;
        bit mc, eale, epsen, erd, ewr, eir;
        string p;
        h = ns / 2;
        es = m[i].hs / 2 + 1;
        eph = m[i].hs % 2;
        win = (es - 1) / h;
        k = m[i].hs - win * 2 * h;
        mc = m[i].mx && m[i].cyc == 0;
        if (m[i].in_rst) begin
            eale = 0; epsen = 1; erd = 1; ewr = 1; eir = 0;
        end else begin
            eale = (k < 2) && !(win == 0 && mc);
            epsen = !((k >= 3) && !(win == 0 && mc));
            erd = !(mc && win == 0 && k >= 1 && !m[i].wr);
            ewr = !(mc && win == 0 && k >= 1 && m[i].wr);
            eir = (es == ns) && (eph == 1) && (m[i].cyc == 0);
        end
        p = $sformatf("N%0d", ns);
        check({p, " Phase"}, ph, eph);
        check({p, " S"}, s, es);
        check({p, " cycles"}, cyc, m[i].cyc);
        check({p, " ALE"}, ale, int'(eale));
        check({p, " PSEN"}, psen, int'(epsen));
        check({p, " RD"}, rd, int'(erd));
        check({p, " WR"}, wr, int'(ewr));
        check({p, " ir_load"}, ir, int'(eir));
        check({p, " waiting"}, wt, int'(m[i].wt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 6, 1'b1);
        model_step(1, 8, 1'b0);
        #1;
        check_inst(0, 6, int'(bus6.Phase), int'(bus6.S), int'(bus6.cycles), int'(bus6.ALE),
                   int'(bus6.PSEN), int'(bus6.RD), int'(bus6.WR), int'(bus6.ir_load),
                   int'(bus6.waiting));
        check_inst(1, 8, int'(bus8.Phase), int'(bus8.S), int'(bus8.cycles), int'(bus8.ALE),
                   int'(bus8.PSEN), int'(bus8.RD), int'(bus8.WR), int'(bus8.ir_load),
                   int'(bus8.waiting));
    endtask

    initial begin
        reset = 1'b1;
        cycles_in = 2'd0;
        movx = 1'b0;
        movx_wr = 1'b0;
        ready = 1'b1;
        for (int blk = 0; blk < 7; blk++) begin
            reset = 1'b1;
            // Direction only changes across a reset so it is stable per access.
            case (blk)
                1: movx_wr = 1'b0;
                2: movx_wr = 1'b1;
                default: movx_wr = 1'($urandom_range(0, 1));
            endcase
            repeat (2) tick();
            reset = 1'b0;
            for (int c = 0; c < 300; c++) begin
                case (blk)
                    0: begin
                        cycles_in = 2'd0;
                        movx = 1'b0;
                        ready = 1'b1;
                    end
                    1, 2: begin
                        cycles_in = 2'd1;
                        movx = 1'b1;
                        ready = ($urandom_range(0, 9) > 1);
                    end
                    3: begin
                        cycles_in = 2'd2;
                        movx = 1'($urandom_range(0, 1));
                        ready = ($urandom_range(0, 9) > 3);
                    end
                    default: begin
                        cycles_in = 2'($urandom_range(0, 3));
                        movx = 1'($urandom_range(0, 1));
                        ready = ($urandom_range(0, 9) > 2);
                        reset = ($urandom_range(0, 149) == 0);
                    end
                endcase
                tick();
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
